data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data memory with a latency-controlled request/response handshake
//
// Purpose: accepts one load/store request at a time, waits LATENCY cycles,
// performs the byte/half/word access on the edge that enters RESP, and holds
// the response until the requester takes it.
//
// Optional feature (macro DMEM_MISALIGN_ERR_EN):
//   defined   - misaligned half/word accesses are rejected (no write, rdata 0, err 1)
//   undefined - misaligned half/word accesses are force-aligned, resp_err is 0
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-low reset
//   req_valid     request present
//   req_ready     request can be accepted (IDLE only)
//   req_write     1 = store, 0 = load
//   req_addr      byte address (bits above the word index are ignored)
//   req_wdata     store data, right-aligned
//   req_size      00 byte, 01 half, 10/11 word
//   req_unsigned  1 = zero-extend loads, 0 = sign-extend
//   resp_valid    response present
//   resp_ready    requester consumes the response
//   resp_rdata    extended load data, 0 for stores and rejected accesses
//   resp_err      access rejected
module data_mem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int AW = IW + 2;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            resp_valid_q;
  logic [31:0]     resp_rdata_q;
  logic            resp_err_q;
  logic            accept, enter_resp, complete;

  logic [31:0]     mem [DEPTH];

  // Only the word index and lane bits of the address matter; the rest wrap.
  if (ADDRESS_WIDTH > AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDRESS_WIDTH-1:AW];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = LAT4;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=0 the access happens on the accept edge itself, so the
  // access fields come straight from the request port while in IDLE.
  logic            acc_write;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [1:0]      acc_size;
  logic            acc_uns;
  logic [1:0]      off;
  logic            misalign;
  logic [IW-1:0]   idx;
  logic [31:0]     old_word, new_word, wrep, load_ext;
  logic [3:0]      be;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            mem_we;

  always_comb begin
    acc_write = (state_q == IDLE) ? req_write      : write_q;
    acc_addr  = (state_q == IDLE) ? req_addr[AW-1:0] : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata      : wdata_q;
    acc_size  = (state_q == IDLE) ? req_size       : size_q;
    acc_uns   = (state_q == IDLE) ? req_unsigned   : uns_q;
  end

  always_comb begin
    idx = acc_addr[AW-1:2];
    // Aligned lane offset; a rejected access never uses it.
    if (acc_size[1])           off = 2'b00;
    else if (acc_size == 2'b01) off = {acc_addr[1], 1'b0};
    else                        off = acc_addr[1:0];
`ifdef DMEM_MISALIGN_ERR_EN
    misalign = ((acc_size == 2'b01) && acc_addr[0]) ||
               (acc_size[1] && (acc_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    old_word = mem[idx];

    if (acc_size[1]) begin
      be   = 4'b1111;
      wrep = acc_wdata;
    end else if (acc_size == 2'b01) begin
      be   = off[1] ? 4'b1100 : 4'b0011;
      wrep = {2{acc_wdata[15:0]}};
    end else begin
      be   = 4'b0001 << off;
      wrep = {4{acc_wdata[7:0]}};
    end
    for (int k = 0; k < 4; k++) begin
      new_word[8*k +: 8] = be[k] ? wrep[8*k +: 8] : old_word[8*k +: 8];
    end

    unique case (off)
      2'd0:    byte_sel = old_word[7:0];
      2'd1:    byte_sel = old_word[15:8];
      2'd2:    byte_sel = old_word[23:16];
      default: byte_sel = old_word[31:24];
    endcase
    half_sel = off[1] ? old_word[31:16] : old_word[15:0];

    if (acc_size[1])            load_ext = old_word;
    else if (acc_size == 2'b01) load_ext = {{16{~acc_uns & half_sel[15]}}, half_sel};
    else                        load_ext = {{24{~acc_uns & byte_sel[7]}}, byte_sel};

    // Gated by rst so a reset on the entering edge drops the store.
    mem_we = rst & enter_resp & acc_write & ~misalign;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= new_word;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= (acc_write | misalign) ? 32'd0 : load_ext;
        resp_err_q   <= misalign;
      end else if (complete) begin
        resp_valid_q <= 1'b0;
        resp_rdata_q <= 32'd0;
        resp_err_q   <= 1'b0;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized checks of data_mem_responder against a byte-level memory model
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int passed = 0;
  int total  = 0;

  // Byte-addressed reference memory covering the 4 KiB that DEPTH=1024 words spans.
  logic [7:0] mb [4096];

  data_mem_responder #(
    .ADDRESS_WIDTH(32),
    .DEPTH(1024),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Little-endian byte model: stores write nb bytes, loads assemble and extend arithmetically.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u,
                       output logic [31:0] rd, output logic err);
    int     nb;
    int     base;
    logic   mis;
    longint v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a % 32'd4096);
    mis  = (base % nb) != 0;
    err  = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    if (mis) begin
      rd  = 32'd0;
      err = 1'b1;
      return;
    end
`else
    if (mis) base = base - (base % nb);
`endif
    if (w) begin
      for (int k = 0; k < nb; k++) mb[base + k] = wd[8*k +: 8];
      rd = 32'd0;
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v = v + (longint'(mb[base + k]) << (8 * k));
      if (!u && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
      rd = v[31:0];
    end
  endtask

  // One full transaction; hold = cycles resp_ready stays low, junk = drive req_valid while held.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic u, input int hold, input logic junk,
                     output logic [31:0] rd_obs);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    model(w, a, wd, sz, u, exp_rd, exp_err);
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    chk("latency", n, LAT + 1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      if (junk) begin
        req_write = 1'b1; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'd2; req_valid = 1'b1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("rdata", resp_rdata, exp_rd);
    chk("err", {31'd0, resp_err}, {31'd0, exp_err});
    chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
    rd_obs = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        rw, ru;
    logic [1:0]  rs;
    logic [31:0] ra;

    // Reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b1;

    // Known contents for the first 16 words
    for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0, 0, 1'b0, rd);

    // Word store/load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, rd);
    chk("store_rdata_zero", rd, 32'd0);
    txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd);
    chk("load_deadbeef", rd, 32'hDEADBEEF);

    // Byte lane merge and extension
    txn(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, 0, 1'b0, rd);
    txn(1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0, 0, 1'b0, rd);
    txn(1'b0, 32'h13, 32'd0, 2'd0, 1'b0, 0, 1'b0, rd);
    chk("byte_signed", rd, 32'hFFFFFF80);
    txn(1'b0, 32'h13, 32'd0, 2'd0, 1'b1, 0, 1'b0, rd);
    chk("byte_unsigned", rd, 32'h00000080);
    txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd);
    chk("word_after_byte", rd, 32'h80223344);

    // Address wrap-around
    txn(1'b0, 32'h4010, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd);
    chk("wrap_load", rd, 32'h80223344);

    // Back-pressure with ignored requests
    txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 5, 1'b1, rd);
    chk("held_load", rd, 32'h80223344);
    txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd);
    chk("no_junk_write", rd, 32'h80223344);

    // Reset during WAIT drops the store
    txn(1'b1, 32'h20, 32'hCAFEF00D, 2'd2, 1'b0, 0, 1'b0, rd);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_wait_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    chk("rst_wait_ready", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd);
    chk("rst_wait_prior", rd, 32'hCAFEF00D);

    // Misaligned word load
    txn(1'b0, 32'h22, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd);
`ifdef DMEM_MISALIGN_ERR_EN
    chk("misalign_rdata", rd, 32'd0);
`else
    chk("misalign_rdata", rd, 32'hCAFEF00D);
`endif

    // Randomized traffic over the initialised region with random high address bits
    for (int i = 0; i < 60; i++) begin
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      txn(rw, ra, $urandom, rs, ru, $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
